// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial front end, MSB first, one bit per CLK.
// Accepts a WIDTH-bit word on a valid/ready handshake and marks the first and
// last bit of each word with seqStart/lastBit.
// Optional build macro SER_SKID_EN adds a one-word holding register so that
// back-to-back words stream with no idle cycle between them.
module word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] wordIn,
  input  logic             wordValid,
  output logic             wordReady,
  output logic             nextBit,
  output logic             bitValid,
  output logic             seqStart,
  output logic             lastBit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             accept;
  logic             lastcyc;
  logic             nextbit_d, bitvalid_d, seqstart_d, lastbit_d, busy_d;

`ifdef SER_SKID_EN
  logic [WIDTH-1:0] skid, skid_d;
  logic             skidfull, skidfull_d;

  // With the holding register a word can be taken whenever it is empty.
  assign wordReady = !skidfull;
`else
  // Without the holding register a word can only be taken while idle.
  assign wordReady = (state == IDLE);
`endif

  // Next-state, shift/count update and the next values of the output flops.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    cnt_d      = cnt;
    accept     = wordValid && wordReady;
    lastcyc    = (state == SHIFT) && (cnt == CW'(1));
`ifdef SER_SKID_EN
    skid_d     = skid;
    skidfull_d = skidfull;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_d = wordIn;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg << 1;
        cnt_d   = cnt - CW'(1);
        if (lastcyc) begin
`ifdef SER_SKID_EN
          // Chain the held word (or one arriving right now) straight into
          // the shifter so its MSB follows the current LSB with no gap.
          if (skidfull) begin
            shreg_d    = skid;
            cnt_d      = CW'(WIDTH);
            skidfull_d = accept;
            if (accept) begin
              skid_d = wordIn;
            end
          end else if (accept) begin
            shreg_d = wordIn;
            cnt_d   = CW'(WIDTH);
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
`ifdef SER_SKID_EN
        else if (accept) begin
          skid_d     = wordIn;
          skidfull_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    nextbit_d  = shreg_d[WIDTH-1];
    bitvalid_d = (state_d == SHIFT);
    seqstart_d = (state_d == SHIFT) && (cnt_d == CW'(WIDTH));
    lastbit_d  = (state_d == SHIFT) && (cnt_d == CW'(1));
`ifdef SER_SKID_EN
    busy_d     = (state_d == SHIFT) || skidfull_d;
`else
    busy_d     = (state_d == SHIFT);
`endif
  end

  // State, datapath and registered outputs; reset aborts any word in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      nextBit  <= 1'b0;
      bitValid <= 1'b0;
      seqStart <= 1'b0;
      lastBit  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      cnt      <= cnt_d;
      nextBit  <= nextbit_d;
      bitValid <= bitvalid_d;
      seqStart <= seqstart_d;
      lastBit  <= lastbit_d;
      busy     <= busy_d;
    end
  end

`ifdef SER_SKID_EN
  // Holding register for a word accepted while another is being shifted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      skid     <= '0;
      skidfull <= 1'b0;
    end else begin
      skid     <= skid_d;
      skidfull <= skidfull_d;
    end
  end
`endif

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: self-checking bench for word_serializer (WIDTH=8 and
// WIDTH=1 instances), using a bit-queue reference model.
module tb_word_serializer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] wordIn;
  logic         wordValid;
  logic         wordReady, nextBit, bitValid, seqStart, lastBit, busy;

  logic [0:0]   wordIn1;
  logic         wordValid1;
  logic         wordReady1, nextBit1, bitValid1, seqStart1, lastBit1, busy1;

  word_serializer #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .wordIn(wordIn), .wordValid(wordValid),
    .wordReady(wordReady), .nextBit(nextBit), .bitValid(bitValid),
    .seqStart(seqStart), .lastBit(lastBit), .busy(busy)
  );

  word_serializer #(.WIDTH(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .wordIn(wordIn1), .wordValid(wordValid1),
    .wordReady(wordReady1), .nextBit(nextBit1), .bitValid(bitValid1),
    .seqStart(seqStart1), .lastBit(lastBit1), .busy(busy1)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic b;
    logic s;
    logic l;
  } bit_ent_t;

  typedef struct {
    logic [7:0] word;
    logic [7:0] expBits;
    logic       expDiv;
  } vec_t;

  bit_ent_t modelQ[$];
  bit_ent_t modelCur;
  logic     modelCurValid = 1'b0;
  logic     capBits[$];
  int       vectors = 0;
  int       miscompares = 0;
  int       cycleNo = 0;
  int       runLen = 0;
  int       maxRun = 0;

  // A whole word waiting behind the current one is what occupies the skid.
  function automatic logic modelSkidFull();
    foreach (modelQ[i]) if (modelQ[i].s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic modelReady();
`ifdef SER_SKID_EN
    return !modelSkidFull();
`else
    return !modelCurValid;
`endif
  endfunction

  function automatic logic [31:0] capValue();
    logic [31:0] v = '0;
    foreach (capBits[i]) v = (v << 1) | 32'(capBits[i]);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  // Reference edge: an accepted word becomes WIDTH queued bits; one pops per cycle.
  task automatic modelEdge(input logic rst, input logic acc, input logic [7:0] w);
    if (rst) begin
      modelQ.delete();
      modelCurValid = 1'b0;
    end else begin
      if (acc)
        for (int i = W - 1; i >= 0; i--)
          modelQ.push_back('{b: w[i], s: (i == W - 1), l: (i == 0)});
      if (modelQ.size() > 0) begin
        modelCur      = modelQ.pop_front();
        modelCurValid = 1'b1;
      end else begin
        modelCurValid = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic valid, input logic [7:0] w, output logic acc);
    logic [4:0] exp;
    RESET     = rst;
    wordValid = valid;
    wordIn    = w;
    checkOutput("wordReady", 32'(wordReady), 32'(modelReady()));
    acc = valid && modelReady() && !rst;
    modelEdge(rst, acc, w);
    @(posedge CLK);
    #1;
    cycleNo++;
    exp = {modelCurValid && modelCur.b, modelCurValid, modelCurValid && modelCur.s,
           modelCurValid && modelCur.l, modelCurValid || modelSkidFull()};
    checkOutput("outputs", 32'({nextBit, bitValid, seqStart, lastBit, busy}), 32'(exp));
    if (bitValid === 1'b1) begin
      capBits.push_back(nextBit);
      runLen++;
      if (runLen > maxRun) maxRun = runLen;
    end else begin
      runLen = 0;
    end
  endtask

  task automatic sendWord(input logic [7:0] w, output int at);
    logic acc = 1'b0;
    int   n = 0;
    at = -1;
    while (!acc && n < 30) begin
      applyStimulus(1'b0, 1'b1, w, acc);
      n++;
    end
    if (acc) at = cycleNo;
    else checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitBits(input int target);
    logic acc;
    int   n = 0;
    while (capBits.size() < target && n < 40) begin
      applyStimulus(1'b0, 1'b0, 8'h00, acc);
      n++;
    end
    if (capBits.size() < target) checkOutput("bits_timeout", 32'(capBits.size()), 32'(target));
  endtask

  initial begin
    vec_t     vecs[6];
    logic     acc;
    int       t1, t2;
    logic     w1[3];
    logic     b1[$];
    int       idx, firstBv, lastBv;
    logic [2:0] b1v;

    vecs[0] = '{8'hB4, 8'b1011_0100, 1'b1};
    vecs[1] = '{8'h03, 8'b0000_0011, 1'b0};
    vecs[2] = '{8'h0C, 8'b0000_1100, 1'b1};
    vecs[3] = '{8'hFF, 8'b1111_1111, 1'b0};
    vecs[4] = '{8'h00, 8'b0000_0000, 1'b1};
    vecs[5] = '{8'hA5, 8'b1010_0101, 1'b0};

    wordValid1 = 1'b0;
    wordIn1    = 1'b0;

    // Reset held for two cycles; the first edge only initialises the DUT.
    RESET = 1'b1; wordValid = 1'b0; wordIn = '0;
    @(posedge CLK);
    #1;
    applyStimulus(1'b1, 1'b0, 8'h00, acc);
    checkOutput("reset_state", 32'({nextBit, bitValid, seqStart, lastBit, busy, wordReady}), 32'b000001);

    // Single words from the table, serialized MSB first.
    foreach (vecs[k]) begin
      capBits.delete();
      sendWord(vecs[k].word, t1);
      waitBits(W);
      checkOutput("serial_bits", capValue(), 32'(vecs[k].expBits));
      checkOutput("is_div4", 32'(capValue() % 4 == 0), 32'(vecs[k].expDiv));
      applyStimulus(1'b0, 1'b0, 8'h00, acc);
    end

    // Two words offered back to back.
    capBits.delete();
    runLen = 0;
    maxRun = 0;
    sendWord(8'h03, t1);
    sendWord(8'h0C, t2);
    waitBits(16);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, acc);
    checkOutput("b2b_bits", capValue(), 32'h030C);
`ifdef SER_SKID_EN
    checkOutput("b2b_accept_gap", 32'(t2 - t1), 32'd1);
    checkOutput("b2b_run", 32'(maxRun), 32'd16);
`else
    checkOutput("b2b_accept_gap", 32'(t2 - t1), 32'd9);
    checkOutput("b2b_run", 32'(maxRun), 32'd8);
`endif

    // Reset in the middle of a word discards the rest of it.
    capBits.delete();
    sendWord(8'hFF, t1);
    waitBits(3);
    applyStimulus(1'b1, 1'b0, 8'h00, acc);
    checkOutput("abort_state", 32'({bitValid, busy, wordReady}), 32'b001);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, acc);
    checkOutput("abort_bits", 32'(capBits.size()), 32'd3);

    // Random traffic with occasional resets against the model.
    for (int i = 0; i < 500; i++)
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, 8'($urandom), acc);
    applyStimulus(1'b1, 1'b0, 8'h00, acc);

    // WIDTH=1 instance: words 1,0,0 held back to back.
    RESET = 1'b0; wordValid = 1'b0;
    w1[0] = 1'b1; w1[1] = 1'b0; w1[2] = 1'b0;
    idx = 0; firstBv = -1; lastBv = -1;
    for (int c = 0; c < 20; c++) begin
      wordValid1 = (idx < 3);
      wordIn1    = (idx < 3) ? w1[idx] : 1'b0;
      acc        = wordValid1 && wordReady1;
      @(posedge CLK);
      #1;
      if (acc) idx++;
      if (bitValid1 === 1'b1) begin
        b1.push_back(nextBit1);
        checkOutput("w1_flags", 32'({seqStart1, lastBit1}), 32'b11);
        if (firstBv < 0) firstBv = c;
        lastBv = c;
      end
    end
    wordValid1 = 1'b0;
    checkOutput("w1_count", 32'(b1.size()), 32'd3);
    b1v = '0;
    foreach (b1[i]) b1v = {b1v[1:0], b1[i]};
    checkOutput("w1_bits", 32'(b1v), 32'b100);
`ifdef SER_SKID_EN
    checkOutput("w1_span", 32'(lastBv - firstBv), 32'd2);
`else
    checkOutput("w1_span", 32'(lastBv - firstBv), 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
